// File: rtl/channel_window_reduce_pkg.sv
// Shared channel package for the reduce-channel stages.
// Holds the window FSM encoding and the drop counter sizing.
package channel_window_reduce_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/channel_window_reduce_if.sv
// Word stream in, window result out, plus the drop statistic.
// master = upstream/downstream environment, slave = the reducer.
interface channel_window_reduce_if
    import channel_window_reduce_pkg::*;
#(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             flush;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [7:0]       out_count;
    logic             out_ready;
    logic [CNT_W-1:0] drop_count;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, out_count, drop_count
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, out_count, drop_count
    );
endinterface

// File: rtl/saturating_counter8.sv
// Counts increment requests and sticks at the all-ones value.
// Used to tally words lost while the result register is blocked.
module saturating_counter8
    import channel_window_reduce_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Increment until saturated; reset clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/channel_window_reduce.sv
// Sums fixed-length windows of an unstoppable word stream.
// Partial windows can be closed early with flush.
module channel_window_reduce
    import channel_window_reduce_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LEN   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    channel_window_reduce_if.slave  bus
);

    localparam logic [7:0] LAST = 8'(LEN - 1);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sum;
    logic [7:0]       count;
    logic             accept;
    logic             drop;

    // The upstream adder cannot stall, so ready only gates acceptance.
    assign bus.in_ready  = (state == ACCUM) || bus.out_ready;
    assign bus.out_valid = (state == HOLD);

    assign accept = bus.in_valid && bus.in_ready;
    assign drop   = bus.in_valid && !bus.in_ready;
    assign sum    = acc + bus.in_data;

    // Window accumulation, result capture and handoff.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ACCUM;
            acc           <= '0;
            count         <= '0;
            bus.out_data  <= '0;
            bus.out_count <= '0;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (accept) begin
                        if ((count == LAST) || bus.flush) begin
                            bus.out_data  <= sum;
                            bus.out_count <= count + 8'd1;
                            acc           <= '0;
                            count         <= '0;
                            state         <= HOLD;
                        end else begin
                            acc   <= sum;
                            count <= count + 8'd1;
                        end
                    end else if (bus.flush && (count != 8'd0)) begin
                        bus.out_data  <= acc;
                        bus.out_count <= count;
                        acc           <= '0;
                        count         <= '0;
                        state         <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        if (accept) begin
                            if (LEN == 1) begin
                                bus.out_data  <= bus.in_data;
                                bus.out_count <= 8'd1;
                            end else begin
                                acc   <= bus.in_data;
                                count <= 8'd1;
                                state <= ACCUM;
                            end
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
            endcase
        end
    end

    saturating_counter8 u_drop (
        .clk   (clk),
        .rst   (rst),
        .inc   (drop),
        .count (bus.drop_count)
    );

endmodule

// File: tb/tb_channel_window_reduce.sv
// Directed vectors for the window reducer.
// Covers LEN=4 windows, wrap, flush, backpressure, reset and LEN=1.
module tb_channel_window_reduce;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    channel_window_reduce_if #(.WIDTH(16)) b4 ();
    channel_window_reduce_if #(.WIDTH(16)) b1 ();

    channel_window_reduce #(.WIDTH(16), .LEN(4)) u4 (
        .clk (clk),
        .rst (rst),
        .bus (b4.slave)
    );

    channel_window_reduce #(.WIDTH(16), .LEN(1)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    typedef struct {
        logic        rst;
        logic        iv;
        logic [15:0] d;
        logic        fl;
        logic        ordy;
        logic        eov;
        logic [15:0] eod;
        logic [7:0]  eoc;
        logic [7:0]  edrop;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic r, logic iv, logic [15:0] d,
                               logic fl, logic ordy, logic eov,
                               logic [15:0] eod, logic [7:0] eoc,
                               logic [7:0] edrop);
        vec_t x;
        x.rst = r; x.iv = iv; x.d = d; x.fl = fl; x.ordy = ordy;
        x.eov = eov; x.eod = eod; x.eoc = eoc; x.edrop = edrop;
        return x;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive4(logic r, logic iv, logic [15:0] d,
                          logic fl, logic ordy);
        @(negedge clk);
        rst          = r;
        b4.in_valid  = iv;
        b4.in_data   = d;
        b4.flush     = fl;
        b4.out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(logic r, logic iv, logic [15:0] d,
                          logic fl, logic ordy);
        @(negedge clk);
        rst          = r;
        b1.in_valid  = iv;
        b1.in_data   = d;
        b1.flush     = fl;
        b1.out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        b4.in_valid = 0; b4.in_data = 0; b4.flush = 0; b4.out_ready = 0;
        b1.in_valid = 0; b1.in_data = 0; b1.flush = 0; b1.out_ready = 0;

        // reset
        tbl.push_back(v(1, 0, 0,      0, 1, 0, 0,  0, 0));
        // 12,17,20,1 -> 50 for one cycle
        tbl.push_back(v(0, 1, 12,     0, 1, 0, 0,  0, 0));
        tbl.push_back(v(0, 1, 17,     0, 1, 0, 0,  0, 0));
        tbl.push_back(v(0, 1, 20,     0, 1, 0, 0,  0, 0));
        tbl.push_back(v(0, 1, 1,      0, 1, 1, 50, 4, 0));
        tbl.push_back(v(0, 0, 0,      0, 1, 0, 0,  0, 0));
        // 4 x 0x4000 wraps to 0
        tbl.push_back(v(0, 1, 16'h4000, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 16'h4000, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 16'h4000, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 16'h4000, 0, 1, 1, 0, 4, 0));
        tbl.push_back(v(0, 0, 0,      0, 1, 0, 0,  0, 0));
        // 3,5 then flush -> 8/2, next window from 0
        tbl.push_back(v(0, 1, 3,      0, 1, 0, 0,  0, 0));
        tbl.push_back(v(0, 1, 5,      0, 1, 0, 0,  0, 0));
        tbl.push_back(v(0, 0, 0,      1, 1, 1, 8,  2, 0));
        tbl.push_back(v(0, 0, 0,      0, 1, 0, 0,  0, 0));
        tbl.push_back(v(0, 1, 1,      0, 1, 0, 0,  0, 0));
        tbl.push_back(v(0, 1, 2,      0, 1, 0, 0,  0, 0));
        tbl.push_back(v(0, 1, 3,      0, 1, 0, 0,  0, 0));
        tbl.push_back(v(0, 1, 4,      0, 1, 1, 10, 4, 0));
        tbl.push_back(v(0, 0, 0,      0, 1, 0, 0,  0, 0));
        // backpressure: 3 drops, then 7 starts next window
        tbl.push_back(v(0, 1, 1,      0, 0, 0, 0,  0, 0));
        tbl.push_back(v(0, 1, 1,      0, 0, 0, 0,  0, 0));
        tbl.push_back(v(0, 1, 1,      0, 0, 0, 0,  0, 0));
        tbl.push_back(v(0, 1, 1,      0, 0, 1, 4,  4, 0));
        tbl.push_back(v(0, 1, 99,     0, 0, 1, 4,  4, 1));
        tbl.push_back(v(0, 1, 99,     0, 0, 1, 4,  4, 2));
        tbl.push_back(v(0, 1, 99,     0, 0, 1, 4,  4, 3));
        tbl.push_back(v(0, 1, 7,      0, 1, 0, 0,  0, 3));
        tbl.push_back(v(0, 1, 1,      0, 1, 0, 0,  0, 3));
        tbl.push_back(v(0, 1, 1,      0, 1, 0, 0,  0, 3));
        tbl.push_back(v(0, 1, 1,      0, 1, 1, 10, 4, 3));
        tbl.push_back(v(0, 0, 0,      0, 1, 0, 0,  0, 3));
        // flush with nothing accumulated is ignored
        tbl.push_back(v(0, 0, 0,      1, 1, 0, 0,  0, 3));
        // flush together with a word -> 6/1
        tbl.push_back(v(0, 1, 6,      1, 1, 1, 6,  1, 3));
        // flush while holding is ignored
        tbl.push_back(v(0, 0, 0,      1, 0, 1, 6,  1, 3));
        tbl.push_back(v(0, 0, 0,      0, 1, 0, 0,  0, 3));
        // reset mid-window, then 1,1,1,1 -> 4
        tbl.push_back(v(0, 1, 1,      0, 1, 0, 0,  0, 3));
        tbl.push_back(v(0, 1, 1,      0, 1, 0, 0,  0, 3));
        tbl.push_back(v(1, 1, 5,      1, 1, 0, 0,  0, 0));
        tbl.push_back(v(0, 1, 1,      0, 1, 0, 0,  0, 0));
        tbl.push_back(v(0, 1, 1,      0, 1, 0, 0,  0, 0));
        tbl.push_back(v(0, 1, 1,      0, 1, 0, 0,  0, 0));
        tbl.push_back(v(0, 1, 1,      0, 1, 1, 4,  4, 0));
        tbl.push_back(v(0, 0, 0,      0, 1, 0, 0,  0, 0));

        foreach (tbl[i]) begin
            drive4(tbl[i].rst, tbl[i].iv, tbl[i].d,
                   tbl[i].fl, tbl[i].ordy);
            chk($sformatf("row%0d out_valid", i),
                int'(b4.out_valid), int'(tbl[i].eov));
            chk($sformatf("row%0d in_ready", i), int'(b4.in_ready),
                int'(!tbl[i].eov || tbl[i].ordy));
            chk($sformatf("row%0d drop_count", i),
                int'(b4.drop_count), int'(tbl[i].edrop));
            if (tbl[i].eov || tbl[i].rst) begin
                chk($sformatf("row%0d out_data", i),
                    int'(b4.out_data), int'(tbl[i].eod));
                chk($sformatf("row%0d out_count", i),
                    int'(b4.out_count), int'(tbl[i].eoc));
            end
        end

        // drop counter saturates at 255 while a result is held
        for (int k = 0; k < 4; k++) drive4(0, 1, 2, 0, 0);
        chk("sat held valid", int'(b4.out_valid), 1);
        for (int k = 0; k < 260; k++) drive4(0, 1, 5, 0, 0);
        chk("sat drop_count", int'(b4.drop_count), 255);
        chk("sat out_data", int'(b4.out_data), 8);
        chk("sat out_count", int'(b4.out_count), 4);
        drive4(0, 0, 0, 0, 1);
        chk("sat release", int'(b4.out_valid), 0);
        chk("sat drop kept", int'(b4.drop_count), 255);
        drive4(1, 0, 0, 0, 0);
        chk("sat reset drop", int'(b4.drop_count), 0);
        chk("sat reset ready", int'(b4.in_ready), 1);

        // LEN=1: every word is a result, valid stays high
        drive1(1, 0, 0, 0, 1);
        chk("len1 reset valid", int'(b1.out_valid), 0);
        chk("len1 reset ready", int'(b1.in_ready), 1);
        drive1(0, 1, 9, 0, 1);
        chk("len1 v9", int'(b1.out_valid), 1);
        chk("len1 d9", int'(b1.out_data), 9);
        chk("len1 c9", int'(b1.out_count), 1);
        drive1(0, 1, 10, 0, 1);
        chk("len1 v10", int'(b1.out_valid), 1);
        chk("len1 d10", int'(b1.out_data), 10);
        chk("len1 c10", int'(b1.out_count), 1);
        drive1(0, 1, 11, 0, 1);
        chk("len1 v11", int'(b1.out_valid), 1);
        chk("len1 d11", int'(b1.out_data), 11);
        chk("len1 c11", int'(b1.out_count), 1);
        chk("len1 drop", int'(b1.drop_count), 0);
        drive1(0, 0, 0, 1, 1);
        chk("len1 idle valid", int'(b1.out_valid), 0);
        drive1(0, 0, 0, 1, 1);
        chk("len1 empty flush", int'(b1.out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
